// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, one clk cycle per serial bit.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Optional build macro UART_TX_TWO_STOP_EN: two stop cycles instead of one;
// the next word is accepted only in the second stop cycle.
// TX_OUT and busy are driven straight from flops so the line never glitches.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b010,
        STOP   = 3'b110
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    par_en_q, par_en_d;
    logic                    par_bit_q, par_bit_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    stop_last;
    logic                    accept;

`ifdef UART_TX_TWO_STOP_EN
    logic                    stop_q, stop_d;
    // second stop cycle is the only one in which a new word may start
    assign stop_last = stop_q;
`else
    assign stop_last = 1'b1;
`endif

    // State, datapath and line registers; reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
            stop_q    <= stop_d;
`endif
        end
    end

    // Next-state logic: each branch decides what the line carries next cycle
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        accept    = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        stop_d    = stop_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                accept = Data_Valid;
            end
            START: begin
                // start bit is on the line; queue data bit 0
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    if (par_en_q) begin
                        tx_d    = par_bit_q;
                        state_d = PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = STOP;
`ifdef UART_TX_TWO_STOP_EN
                        stop_d  = 1'b0;
`endif
                    end
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                tx_d    = 1'b1;
                state_d = STOP;
`ifdef UART_TX_TWO_STOP_EN
                stop_d  = 1'b0;
`endif
            end
            STOP: begin
                if (!stop_last) begin
`ifdef UART_TX_TWO_STOP_EN
                    stop_d = 1'b1;
`endif
                    tx_d   = 1'b1;
                end else if (Data_Valid) begin
                    accept = 1'b1;
                end else begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Latch the word and its configuration; the start bit goes out next cycle
        if (accept) begin
            shift_d   = P_DATA;
            par_en_d  = PAR_EN;
            par_bit_d = (^P_DATA) ^ PAR_TYP;
            cnt_d     = '0;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            state_d   = START;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scenario tasks checked against a frame-queue reference model.
// The model holds the bits still to appear on the line; a new word is only
// taken when nothing of the current frame is left after the bit now showing.
module tb_uart_tx_frame;

    localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif
    localparam int FLEN = DW + 1 + NSTOP;   // frame length without parity

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          TX_OUT;
    logic          busy;

    int   n_checks = 0;
    int   n_fail = 0;
    logic mq[$];
    logic exp_tx, exp_busy, obs_tx, obs_busy;

    uart_tx_frame #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic push_frame(input logic [DW-1:0] d, input logic pen, input logic pt);
        mq.push_back(1'b0);
        for (int k = 0; k < DW; k++) mq.push_back(d[k]);
        if (pen) mq.push_back((^d) ^ pt);
        for (int k = 0; k < NSTOP; k++) mq.push_back(1'b1);
    endtask

    // Apply inputs for one edge, advance the model, sample the DUT after the edge
    task automatic drive_cycle(input logic dv, input logic [DW-1:0] d,
                               input logic pen, input logic pt);
        Data_Valid = dv;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = pt;
        @(posedge clk);
        if (!rst_n) mq.delete();
        else if (dv && mq.size() == 0) push_frame(d, pen, pt);
        if (rst_n && mq.size() > 0) begin
            exp_tx   = mq.pop_front();
            exp_busy = 1'b1;
        end else begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end
        #1;
        obs_tx     = TX_OUT;
        obs_busy   = busy;
        Data_Valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: tx=%b busy=%b required tx=1 busy=0", TX_OUT, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, DW'($urandom), 1'b0, 1'b0);
            n_checks++;
            if (obs_tx !== 1'b1 || obs_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_reset cyc %0d: tx=%b busy=%b required 1/0", i, obs_tx, obs_busy);
            end
        end
        $display("tx frame data=5a (reset mid-frame)");
        drive_cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (obs_tx !== exp_tx || obs_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_data: tx=%b busy=%b required tx=%b busy=1", obs_tx, obs_busy, exp_tx);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: tx=%b busy=%b required tx=1 busy=0", TX_OUT, busy);
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
            n_checks++;
            if (obs_tx !== 1'b1 || obs_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL line_after_abort cyc %0d: tx=%b busy=%b required 1/0", i, obs_tx, obs_busy);
            end
        end
    endtask

    task automatic test_no_parity();
        logic [0:10] seq;
        logic        want_tx, want_busy;
        seq = 11'b01010010111;
        $display("tx frame data=a5 no parity");
        for (int i = 0; i < FLEN + 3; i++) begin
            drive_cycle(i == 0, 8'hA5, 1'b0, 1'b0);
            want_tx   = (i < FLEN) ? seq[i] : 1'b1;
            want_busy = (i < FLEN);
            n_checks++;
            if (obs_tx !== want_tx || obs_busy !== want_busy) begin
                n_fail++;
                $display("FAIL no_parity cyc %0d: tx=%b busy=%b required tx=%b busy=%b",
                         i, obs_tx, obs_busy, want_tx, want_busy);
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] pd [4] = '{8'hA5, 8'hA5, 8'h07, 8'h07};
        logic       pt [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       pb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 4; t++) begin
            $display("tx frame data=%h parity typ=%b", pd[t], pt[t]);
            for (int i = 0; i < FLEN + 3; i++) begin
                drive_cycle(i == 0, pd[t], 1'b1, pt[t]);
                n_checks++;
                if (obs_tx !== exp_tx || obs_busy !== exp_busy) begin
                    n_fail++;
                    $display("FAIL parity_frame %0d cyc %0d: tx=%b busy=%b required tx=%b busy=%b",
                             t, i, obs_tx, obs_busy, exp_tx, exp_busy);
                end
                if (i == DW + 1) begin
                    n_checks++;
                    if (obs_tx !== pb[t]) begin
                        n_fail++;
                        $display("FAIL parity_bit %0d: got %b required %b", t, obs_tx, pb[t]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        $display("tx frames data=3c then ff back-to-back");
        for (int i = 0; i < 2 * FLEN + 3; i++) begin
            drive_cycle(i == 0 || i == FLEN, (i == FLEN) ? 8'hFF : 8'h3C, 1'b0, 1'b0);
            n_checks++;
            if (obs_tx !== exp_tx || obs_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL b2b cyc %0d: tx=%b busy=%b required tx=%b busy=%b",
                         i, obs_tx, obs_busy, exp_tx, exp_busy);
            end
            if (i < 2 * FLEN) begin
                n_checks++;
                if (obs_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_busy cyc %0d: busy=%b required 1", i, obs_busy);
                end
            end
            if (i == FLEN) begin
                n_checks++;
                if (obs_tx !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_start: tx=%b required 0", obs_tx);
                end
            end
        end
    endtask

    task automatic test_ignore_midframe();
        logic want_tx;
        $display("tx frame data=55 with ignored strobe and churning inputs");
        for (int i = 0; i < FLEN + 4; i++) begin
            if (i == 0)      drive_cycle(1'b1, 8'h55, 1'b0, 1'b0);
            else if (i == 5) drive_cycle(1'b1, 8'h00, 1'b0, 1'b0);
            else             drive_cycle(1'b0, DW'($urandom), 1'($urandom_range(0, 1)),
                                         1'($urandom_range(0, 1)));
            if (i == 0)      want_tx = 1'b0;
            else if (i <= DW) want_tx = 1'(i % 2);
            else             want_tx = 1'b1;
            n_checks++;
            if (obs_tx !== want_tx || obs_busy !== (i < FLEN)) begin
                n_fail++;
                $display("FAIL ignore cyc %0d: tx=%b busy=%b required tx=%b busy=%b",
                         i, obs_tx, obs_busy, want_tx, (i < FLEN));
            end
        end
    endtask

`ifdef UART_TX_TWO_STOP_EN
    task automatic test_two_stop();
        $display("tx frame data=a5 two stop, then 81 from second stop cycle");
        for (int i = 0; i < 2 * FLEN + 3; i++) begin
            if (i == 0)       drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0);
            else if (i == 10) drive_cycle(1'b1, 8'h00, 1'b0, 1'b0);
            else if (i == 11) drive_cycle(1'b1, 8'h81, 1'b0, 1'b0);
            else              drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
            n_checks++;
            if (obs_tx !== exp_tx || obs_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL two_stop cyc %0d: tx=%b busy=%b required tx=%b busy=%b",
                         i, obs_tx, obs_busy, exp_tx, exp_busy);
            end
            if (i >= 9 && i <= 11) begin
                n_checks++;
                if (obs_tx !== (i != 11) || obs_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL two_stop_window cyc %0d: tx=%b busy=%b required tx=%b busy=1",
                             i, obs_tx, obs_busy, (i != 11));
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        logic dv;
        int   sent;
        sent = 0;
        for (int i = 0; i < 400; i++) begin
            dv = ($urandom_range(0, 3) == 0);
            if (dv && mq.size() == 0) sent++;
            drive_cycle(dv, DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_checks++;
            if (obs_tx !== exp_tx || obs_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL random cyc %0d: tx=%b busy=%b required tx=%b busy=%b",
                         i, obs_tx, obs_busy, exp_tx, exp_busy);
            end
        end
        for (int i = 0; i < FLEN + 3; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
            n_checks++;
            if (obs_tx !== exp_tx || obs_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL random_drain cyc %0d: tx=%b busy=%b required tx=%b busy=%b",
                         i, obs_tx, obs_busy, exp_tx, exp_busy);
            end
        end
        $display("random run: %0d frames accepted", sent);
    endtask

    initial begin
        #2;
        test_reset();
        test_no_parity();
        test_parity();
        test_back_to_back();
        test_ignore_midframe();
`ifdef UART_TX_TWO_STOP_EN
        test_two_stop();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter for the UART block. It is the send-side counterpart of the UART receive path and uses the same frame format: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, stop bit.
- Runs on the TX baud clock: one clk cycle per serial bit, no oversampling.
- Accepts a parallel word through a single-cycle valid handshake.
- Drives the serial line from a registered output.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).

Ports:
clk  input  1  TX baud clock; one bit period per cycle.
rst_n  input  1  asynchronous, active-low reset.
P_DATA  input  DATA_WIDTH  parallel data word to send.
Data_Valid  input  1  one-cycle strobe; P_DATA, PAR_EN and PAR_TYP are valid in this cycle.
PAR_EN  input  1  1 = insert a parity bit after the data bits.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
TX_OUT  output  1  serial line; idles high. Registered.
busy  output  1  1 while a frame is on the line. Registered.

Behaviour:
- Reset (asynchronous, may occur mid-frame):
  - TX_OUT=1, busy=0, state=IDLE.
  - Shift register, bit counter and latched configuration are cleared.
  - Any partial frame is abandoned with no further line activity.
- States: IDLE(000), START(001), DATA(011), PARITY(010), STOP(110). Gray-style encoding.
- Acceptance window: Data_Valid is sampled at posedge only when state=IDLE, or when state=STOP in its final stop cycle.
  - Data_Valid at any other time is ignored. The word is dropped, with no error flag and no effect on the current frame.
- On accept:
  - Latch P_DATA, PAR_EN and PAR_TYP into internal registers. Later changes on these inputs do not affect the frame in flight.
  - Compute parity from the latched data: XOR-reduce, inverted when PAR_TYP=1.
- Cycle timing, with accept at edge N:
  - Edge N: TX_OUT<=0 (start bit), busy<=1, state->START. TX_OUT is 0 during cycle N+1.
  - DATA: TX_OUT carries data bit k during cycle N+2+k, LSB first, k=0..DATA_WIDTH-1. A bit counter of width $clog2(DATA_WIDTH+1) counts 0..DATA_WIDTH-1. Leave DATA when it reaches DATA_WIDTH-1.
  - PARITY (only if latched PAR_EN=1): one cycle carrying the parity bit.
  - STOP: one cycle with TX_OUT=1, busy=1.
- End of STOP cycle:
  - If Data_Valid=1: accept the new word. TX_OUT<=0 and state->START immediately, with no idle gap between frames. busy stays 1.
  - Otherwise: state->IDLE, busy<=0, TX_OUT stays 1.
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity.
- TX_OUT must be glitch-free: driven from a flop, never directly from a combinational mux.
- Illegal or unreachable state encodings return to IDLE on the next edge with TX_OUT<=1 and busy<=0.

Optional Feature:
Macro UART_TX_TWO_STOP_EN.
- Defined: STOP lasts two cycles, both with TX_OUT=1 and busy=1. The acceptance window is the second stop cycle only. Frame length increases by 1.
- Undefined: exactly one stop cycle, as described above.
- No port or parameter changes either way.

Test Plan:
1. Reset: assert rst_n=0 mid-frame during DATA -> TX_OUT=1 and busy=0 immediately. After release with no Data_Valid, the line stays at 1 for 20 cycles.
2. No parity: P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1. busy=1 for exactly 10 cycles, then 0.
3. Parity: P_DATA=0xA5 with PAR_EN=1 -> 11-bit frame. PAR_TYP=0 gives parity bit 0 (four ones). PAR_TYP=1 gives parity bit 1. Repeat with 0x07: even gives 1, odd gives 0.
4. Back-to-back: 0x3C, then Data_Valid with 0xFF in the stop cycle -> the stop bit (1) is followed directly by a start bit (0). The second frame is 1,1,1,1,1,1,1,1 for data. busy never drops between the two frames.
5. Busy drop and input change: Data_Valid with 0x00 in the 4th data cycle of a 0x55 frame -> the 0x55 frame completes unaltered and 0x00 is never sent. Changing P_DATA, PAR_EN or PAR_TYP mid-frame has no effect on the line.
6. With UART_TX_TWO_STOP_EN defined: 0xA5, no parity -> 11 cycles ending 1,1. Data_Valid in the first stop cycle is ignored; Data_Valid in the second stop cycle is accepted.
